psum_drain_quant: RTL and testbench
===================================

# psum_drain_quant

Output drain stage placed directly downstream of the NxN systolic MAC array. When the array signals completion, the block captures the full NxN matrix of 20-bit unsigned partial sums and pulses a clear back to the array. It then requantizes each element to 8 bits (round, right-shift, saturate) and streams the result to the output buffer SRAM one row per beat over a valid/ready write port. This frees the array to start the next tile while the previous result is drained.

## Interface
- N, 8, array dimension; rows drained per tile
- PSUM_W, 20, partial-sum width (unsigned)
- OUT_W, 8, quantized element width (unsigned)
- ADDR_W, 13, output buffer address width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- done_in  in  1  one-cycle completion pulse from array
- psum_in  in  N*N*PSUM_W  packed [N-1:0][N-1:0][PSUM_W-1:0] array results; stable when done_in is high
- shift_amt  in  5  right-shift amount, 0..19; values above 19 are treated as 19
- round_en  in  1  1: round half-up before shift; 0: truncate
- base_addr  in  ADDR_W  address of row 0 of the tile
- clear_out  out  1  one-cycle pulse to zero the array accumulators
- wr_valid  out  1  row beat valid
- wr_ready  in  1  output buffer accepts beat
- wr_addr  out  ADDR_W  row address
- wr_data  out  N*OUT_W  packed [N-1:0][OUT_W-1:0] quantized row, column j in slice j
- busy  out  1  high while in DRAIN
- drain_done  out  1  one-cycle pulse after last row accepted
- sat_flag  out  1  at least one element of the current/last tile saturated
- overrun  out  1  sticky: done_in arrived while busy; cleared only by reset

## Operation
- States: IDLE, DRAIN. Reset enters IDLE. All registers, including the capture buffer, reset to 0.
- IDLE, done_in=1:
  - capture psum_in into the local buffer
  - latch shift_amt, round_en, base_addr
  - row counter to 0
  - clear sat_flag
  - go to DRAIN
- DRAIN:
  - wr_valid=1
  - wr_addr = base_addr_latched + row, modulo 2^ADDR_W
  - wr_data = quant(buffer[row][*])
  - On wr_valid&&wr_ready:
    - if row==N-1, go to IDLE and pulse drain_done
    - else row increments
  - wr_valid stays asserted while wr_ready=0; wr_addr and wr_data are held stable.
- Quant per element x:
  - t = x + (round_en && s>0 ? 2^(s-1) : 0), computed at PSUM_W+1 bits so no wrap
  - y = t >> s
  - out = (y > 2^OUT_W-1) ? 2^OUT_W-1 : y
- sat_flag is set when an accepted beat contains any saturated element. It holds until the next capture.
- done_in while in DRAIN: ignored, buffer untouched, overrun set.
- Config input changes during DRAIN have no effect.

## Timing
- Reset values: clear_out=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, drain_done=0, sat_flag=0, overrun=0.
- done_in high in cycle T → capture at edge T. In cycle T+1: busy=1, wr_valid=1 with row 0, clear_out=1 for exactly that cycle.
- wr_data and wr_addr are derived only from registered state; there is no combinational path from any input to them.
- With wr_ready held high: rows 0..N-1 transfer in cycles T+1..T+N. drain_done=1 and busy=0 in cycle T+N+1.
- done_in in the same cycle as the final accepting handshake counts as arriving while busy: it is ignored and sets overrun.
- rst_n asserted mid-drain aborts immediately: wr_valid drops asynchronously and no drain_done is issued.

## Structure
- Shared package holds:
  - the state enum {IDLE, DRAIN}
  - PSUM_W and OUT_W defaults
  - typedefs psum_t (logic [PSUM_W-1:0]) and q_t (logic [OUT_W-1:0])
- One sub-module, quant_elem: purely combinational round/shift/saturate of one element, outputs the value and a sat bit. Instantiated N times (one row, muxed by row counter).

## Test plan
- All psum=1000, shift=2, round off, base=0x100, ready=1 → 8 beats at addrs 0x100..0x107, every byte 250. clear_out 1 cycle after done_in. drain_done at T+9. sat_flag=0.
- psum=6, shift=2, round on → 2. psum=5 → 1. shift=0, round on → 6 (no rounding term).
- psum=0xFFFFF, shift=4, round on → t=0x100007, y=0x10000, out=255, sat_flag=1.
- wr_ready low for 3 cycles on row 3 → wr_data/wr_addr stable, no row skipped or duplicated. 8 accepted beats total.
- done_in pulsed during row 5 → overrun=1, remaining rows carry original tile data, new psum_in is not captured.
- base=0x1FFC → addrs 0x1FFC..0x1FFF, then 0x0000..0x0003. Reset asserted after row 2 → all outputs at reset values. Next done_in drains normally from row 0.

Source files
------------

// File: rtl/psum_drain_quant_pkg.sv
// Shared types and widths for the partial-sum drain/requantize stage.
package psum_drain_quant_pkg;

    localparam int PSUM_W = 20;
    localparam int OUT_W  = 8;

    typedef logic [PSUM_W-1:0] psum_t;
    typedef logic [OUT_W-1:0]  q_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/psum_drain_quant_quant_elem.sv
// Combinational round / right-shift / saturate of a single partial sum.
module quant_elem
    import psum_drain_quant_pkg::*;
(
    input  psum_t      x,
    input  logic [4:0] shift,
    input  logic       round_en,
    output q_t         y,
    output logic       sat
);

    localparam logic [PSUM_W:0] ONE = 1;

    logic [PSUM_W:0] rnd;
    logic [PSUM_W:0] t;
    logic [PSUM_W:0] q;

    // One extra bit on the sum so the rounding term can never wrap.
    always_comb begin
        rnd = '0;
        if (round_en && (shift != 5'd0)) begin
            rnd = ONE << (shift - 5'd1);
        end
        t   = {1'b0, x} + rnd;
        q   = t >> shift;
        sat = |q[PSUM_W:OUT_W];
        y   = sat ? '1 : q[OUT_W-1:0];
    end

endmodule

// File: rtl/psum_drain_quant.sv
// Captures the NxN partial-sum tile on done_in and drains it row by row,
// requantized to OUT_W bits, over a valid/ready write port.
module psum_drain_quant
    import psum_drain_quant_pkg::*;
#(
    parameter int N      = 8,
    parameter int ADDR_W = 13
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              done_in,
    input  logic [N-1:0][N-1:0][PSUM_W-1:0]   psum_in,
    input  logic [4:0]                        shift_amt,
    input  logic                              round_en,
    input  logic [ADDR_W-1:0]                 base_addr,
    output logic                              clear_out,
    output logic                              wr_valid,
    input  logic                              wr_ready,
    output logic [ADDR_W-1:0]                 wr_addr,
    output logic [N-1:0][OUT_W-1:0]           wr_data,
    output logic                              busy,
    output logic                              drain_done,
    output logic                              sat_flag,
    output logic                              overrun
);

    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

    state_t                          state_reg, state_next;
    logic [N-1:0][N-1:0][PSUM_W-1:0] buf_reg;
    logic [4:0]                      shift_reg;
    logic                            round_reg;
    logic [ADDR_W-1:0]               base_reg;
    logic [ROW_W-1:0]                row_reg;
    logic                            clear_reg;
    logic                            done_reg;
    logic                            sat_reg;
    logic                            overrun_reg;
    logic [N-1:0]                    col_sat;

    logic capture;
    logic accept;
    logic last_beat;

    assign capture   = (state_reg == IDLE) && done_in;
    assign accept    = (state_reg == DRAIN) && wr_ready;
    assign last_beat = accept && (row_reg == LAST_ROW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (capture)   state_next = DRAIN;
            DRAIN:   if (last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_reg     <= '0;
            shift_reg   <= '0;
            round_reg   <= 1'b0;
            base_reg    <= '0;
            row_reg     <= '0;
            clear_reg   <= 1'b0;
            done_reg    <= 1'b0;
            sat_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            clear_reg <= capture;
            done_reg  <= last_beat;
            if (capture) begin
                buf_reg   <= psum_in;
                shift_reg <= (shift_amt > 5'd19) ? 5'd19 : shift_amt;
                round_reg <= round_en;
                base_reg  <= base_addr;
                row_reg   <= '0;
                sat_reg   <= 1'b0;
            end else if (accept) begin
                if (!last_beat) begin
                    row_reg <= row_reg + 1'b1;
                end
                if (|col_sat) begin
                    sat_reg <= 1'b1;
                end
            end
            // A completion while draining (including the final beat) is dropped.
            if (done_in && (state_reg == DRAIN)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_col
        quant_elem u_quant (
            .x        (buf_reg[row_reg][gi]),
            .shift    (shift_reg),
            .round_en (round_reg),
            .y        (wr_data[gi]),
            .sat      (col_sat[gi])
        );
    end

    assign wr_valid   = (state_reg == DRAIN);
    assign busy       = (state_reg == DRAIN);
    assign wr_addr    = base_reg + ADDR_W'(row_reg);
    assign clear_out  = clear_reg;
    assign drain_done = done_reg;
    assign sat_flag   = sat_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_psum_drain_quant.sv
// Randomized self-checking bench for psum_drain_quant against an arithmetic model.
module tb_psum_drain_quant;

    localparam int N = 8;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        done_in = 1'b0;
    logic [N-1:0][N-1:0][19:0]   psum_in = '0;
    logic [4:0]                  shift_amt = '0;
    logic                        round_en = 1'b0;
    logic [12:0]                 base_addr = '0;
    logic                        clear_out;
    logic                        wr_valid;
    logic                        wr_ready = 1'b1;
    logic [12:0]                 wr_addr;
    logic [N-1:0][7:0]           wr_data;
    logic                        busy;
    logic                        drain_done;
    logic                        sat_flag;
    logic                        overrun;

    int total = 0;
    int bad   = 0;
    bit overrun_exp = 1'b0;
    int tile_no = 0;
    logic [N-1:0][N-1:0][19:0] tile;

    psum_drain_quant #(.N(N), .ADDR_W(13)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .done_in    (done_in),
        .psum_in    (psum_in),
        .shift_amt  (shift_amt),
        .round_en   (round_en),
        .base_addr  (base_addr),
        .clear_out  (clear_out),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .drain_done (drain_done),
        .sat_flag   (sat_flag),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Unsaturated quantized value: round half-up, then divide by 2^s.
    function automatic longint quant_raw(input longint x, input int s, input bit r);
        int sc;
        longint t;
        sc = (s > 19) ? 19 : s;
        t  = x + ((r && sc > 0) ? (longint'(1) << (sc - 1)) : 0);
        return t / (longint'(1) << sc);
    endfunction

    function automatic logic [N-1:0][N-1:0][19:0] rand_tile();
        logic [N-1:0][N-1:0][19:0] t;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                t[r][c] = 20'($urandom);
        return t;
    endfunction

    // Launches the current tile, then checks every cycle of the drain.
    task automatic run_tile(input int sh, input bit rn, input logic [12:0] base,
                            input int stall_row, input int ovr_row, input int abort_row);
        logic [N-1:0][N-1:0][19:0] snap;
        logic [N-1:0][7:0]         exp_row;
        logic [12:0]               exp_addr;
        longint                    y;
        int  row, cyc, stalls;
        bit  sat_exp, row_sat, rdy, ovr_done;
        snap      = tile;
        psum_in   = tile;
        shift_amt = 5'(sh);
        round_en  = rn;
        base_addr = base;
        done_in   = 1'b1;
        @(posedge clk); #1;
        done_in   = 1'b0;
        psum_in   = rand_tile();
        shift_amt = 5'($urandom);
        round_en  = ~rn;
        base_addr = 13'($urandom);
        row = 0; cyc = 0; stalls = 0; sat_exp = 0; ovr_done = 0;
        while (row < N && cyc < 200) begin
            if (row == abort_row) begin
                rst_n = 1'b0;
                #1;
                total++;
                if ({clear_out, wr_valid, wr_addr, wr_data, busy, drain_done, sat_flag, overrun} !== '0) begin
                    bad++;
                    $display("FAIL abort_reset: valid=%b busy=%b addr=%h data=%h done=%b sat=%b ovr=%b, required all 0",
                             wr_valid, busy, wr_addr, wr_data, drain_done, sat_flag, overrun);
                end
                overrun_exp = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                $display("tile %0d: aborted by reset at row %0d", tile_no, row);
                tile_no++;
                return;
            end
            exp_addr = base + 13'(row);
            row_sat  = 1'b0;
            for (int c = 0; c < N; c++) begin
                y = quant_raw(longint'(snap[row][c]), sh, rn);
                if (y > 255) begin
                    row_sat    = 1'b1;
                    exp_row[c] = 8'd255;
                end else begin
                    exp_row[c] = 8'(y);
                end
            end
            total++;
            if (wr_valid !== 1'b1 || busy !== 1'b1 || drain_done !== 1'b0 || clear_out !== (cyc == 0)) begin
                bad++;
                $display("FAIL ctrl row%0d cyc%0d: valid=%b busy=%b done=%b clear=%b, required 1 1 0 %0b",
                         row, cyc, wr_valid, busy, drain_done, clear_out, cyc == 0);
            end
            total++;
            if (wr_addr !== exp_addr) begin
                bad++;
                $display("FAIL addr row%0d: got %h, required %h", row, wr_addr, exp_addr);
            end
            total++;
            if (wr_data !== exp_row) begin
                bad++;
                $display("FAIL data row%0d: got %h, required %h", row, wr_data, exp_row);
            end
            rdy = 1'b1;
            if (row == stall_row && stalls < 3) begin
                rdy = 1'b0;
                stalls++;
            end else if (stall_row >= 0 && row != ovr_row && $urandom_range(3) == 0) begin
                rdy = 1'b0;
            end
            wr_ready = rdy;
            if (row == ovr_row && !ovr_done && rdy) begin
                done_in     = 1'b1;
                psum_in     = rand_tile();
                ovr_done    = 1'b1;
                overrun_exp = 1'b1;
            end
            @(posedge clk); #1;
            done_in = 1'b0;
            if (rdy) begin
                row++;
                sat_exp |= row_sat;
            end
            cyc++;
        end
        wr_ready = 1'b1;
        total++;
        if (row != N) begin
            bad++;
            $display("FAIL drain_timeout: rows accepted %0d, required %0d", row, N);
        end
        total++;
        if (drain_done !== 1'b1 || busy !== 1'b0 || wr_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_end: done=%b busy=%b valid=%b, required 1 0 0", drain_done, busy, wr_valid);
        end
        total++;
        if (sat_flag !== sat_exp) begin
            bad++;
            $display("FAIL sat_flag: got %b, required %b", sat_flag, sat_exp);
        end
        total++;
        if (overrun !== overrun_exp) begin
            bad++;
            $display("FAIL overrun: got %b, required %b", overrun, overrun_exp);
        end
        @(posedge clk); #1;
        total++;
        if (drain_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_drain: done=%b busy=%b, required 0 0", drain_done, busy);
        end
        $display("tile %0d: shift=%0d round=%0b base=%h beats=%0d cycles=%0d sat=%0b",
                 tile_no, sh, rn, base, row, cyc, sat_exp);
        tile_no++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        psum_in = rand_tile();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({clear_out, wr_valid, wr_addr, wr_data, busy, drain_done, sat_flag, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_state: valid=%b busy=%b addr=%h data=%h done=%b sat=%b ovr=%b, required all 0",
                     wr_valid, busy, wr_addr, wr_data, drain_done, sat_flag, overrun);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                tile[r][c] = 20'd1000;
        run_tile(2, 1'b0, 13'h100, -1, -1, -1);
    endtask

    task automatic test_round();
        tile = rand_tile();
        for (int c = 0; c < N; c++) begin
            tile[0][c] = 20'd6;
            tile[1][c] = 20'd5;
        end
        run_tile(2, 1'b1, 13'h040, -1, -1, -1);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                tile[r][c] = 20'd6;
        run_tile(0, 1'b1, 13'h080, -1, -1, -1);
        for (int k = 0; k < 6; k++) begin
            tile = rand_tile();
            for (int c = 0; c < N; c++)
                tile[k][c] = 20'($urandom_range(4000));
            run_tile(int'($urandom_range(31)), 1'($urandom), 13'($urandom), -1, -1, -1);
        end
    endtask

    task automatic test_sat();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                tile[r][c] = 20'hFFFFF;
        run_tile(4, 1'b1, 13'h200, -1, -1, -1);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                tile[r][c] = 20'($urandom_range(65535));
        run_tile(19, 1'b1, 13'h300, -1, -1, -1);
    endtask

    task automatic test_backpressure();
        tile = rand_tile();
        run_tile(14, 1'b0, 13'h400, 3, -1, -1);
        tile = rand_tile();
        run_tile(12, 1'b1, 13'h500, 0, -1, -1);
    endtask

    task automatic test_overrun();
        tile = rand_tile();
        run_tile(13, 1'b1, 13'h600, -1, 5, -1);
        tile = rand_tile();
        run_tile(15, 1'b0, 13'h700, -1, N - 1, -1);
    endtask

    task automatic test_wrap_reset();
        tile = rand_tile();
        run_tile(12, 1'b1, 13'h1FFC, -1, -1, 3);
        tile = rand_tile();
        run_tile(12, 1'b1, 13'h1FFC, -1, -1, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_sat();
        test_backpressure();
        test_overrun();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
